// File: rtl/amo_sequencer.sv
// Read/modify/write sequencer for LR.W, SC.W and AMO*.W in the MEM stage.
// Stalls the pipeline, drives the data-memory port and owns the LR/SC reservation.
module amo_sequencer #(
   parameter int ADDR_W   = 32,
   parameter int RESV_LSB = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_lr,
   input  logic              is_sc,
   input  logic              is_amo,
   input  logic [4:0]        amo_funct5,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       rs2_data,
   input  logic              resv_clear,
   input  logic              snoop_we,
   input  logic [ADDR_W-1:0] snoop_addr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic [31:0]       result,
   output logic              misaligned,
   output logic              resv_valid
);

   localparam int GW = ADDR_W - RESV_LSB;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2, S_DONE = 2'd3} state_e;
   typedef enum logic [1:0] {OP_LR = 2'd0, OP_SC = 2'd1, OP_AMO = 2'd2} op_e;

   state_e            state_q, state_d;
   op_e               op_q, op_d, op_in;
   logic [ADDR_W-1:2] addr_q, addr_d;
   logic [31:0]       rs2_q, rs2_d;
   logic [4:0]        f5_q, f5_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       result_q, result_d;
   logic              misal_q, misal_d;
   logic              resv_valid_q, resv_valid_d;
   logic [GW-1:0]     resv_addr_q, resv_addr_d;
   logic              resv_set, resv_clr;
   logic [GW-1:0]     addr_g, snoop_g;
   logic              unused_in;

   assign unused_in = ^{is_amo, snoop_addr[RESV_LSB-1:0]};
   assign addr_g    = addr_q[ADDR_W-1:RESV_LSB];
   assign snoop_g   = snoop_addr[ADDR_W-1:RESV_LSB];
   assign op_in     = is_lr ? OP_LR : (is_sc ? OP_SC : OP_AMO);

   function automatic logic [31:0] amo_modify(input logic [4:0]  f5,
                                              input logic [31:0] old,
                                              input logic [31:0] rs2);
      logic signed [31:0] old_s;
      logic signed [31:0] rs2_s;
      logic [31:0]        r;
      old_s = old;
      rs2_s = rs2;
      case (f5)
         5'b00000: r = old + rs2;
         5'b00100: r = old ^ rs2;
         5'b01100: r = old & rs2;
         5'b01000: r = old | rs2;
         5'b10000: r = (old_s < rs2_s) ? old : rs2;
         5'b10100: r = (old_s < rs2_s) ? rs2 : old;
         5'b11000: r = (old < rs2) ? old : rs2;
         5'b11100: r = (old < rs2) ? rs2 : old;
         default:  r = rs2;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      rs2_d    = rs2_q;
      f5_d     = f5_q;
      wdata_d  = wdata_q;
      result_d = result_q;
      misal_d  = 1'b0;
      resv_set = 1'b0;
      resv_clr = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d = addr[ADDR_W-1:2];
               rs2_d  = rs2_data;
               f5_d   = amo_funct5;
               op_d   = op_in;
               if (addr[1:0] != 2'b00) begin
                  state_d  = S_DONE;
                  misal_d  = 1'b1;
                  result_d = 32'd0;
                  resv_clr = (op_in == OP_SC);
               end else if (op_in != OP_SC) begin
                  state_d = S_RD;
               end else if (resv_valid_q && (addr[ADDR_W-1:RESV_LSB] == resv_addr_q)) begin
                  state_d = S_WR;
                  wdata_d = rs2_data;
               end else begin
                  state_d  = S_DONE;
                  result_d = 32'd1;
                  resv_clr = 1'b1;
               end
            end
         end
         S_RD: begin
            if (mem_ready) begin
               result_d = mem_rdata;
               if (op_q == OP_LR) begin
                  resv_set = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  wdata_d = amo_modify(f5_q, mem_rdata, rs2_q);
                  state_d = S_WR;
               end
            end
         end
         S_WR: begin
            if (mem_ready) begin
               if (op_q == OP_SC) begin
                  result_d = 32'd0;
                  resv_clr = 1'b1;
               end else if (addr_g == resv_addr_q) begin
                  // Our own AMO store hits the reserved granule like any other store.
                  resv_clr = 1'b1;
               end
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (resv_clear || (snoop_we && ((snoop_g == resv_addr_q) || (resv_set && snoop_g == addr_g)))) begin
         resv_clr = 1'b1;
      end
      resv_addr_d  = resv_set ? addr_g : resv_addr_q;
      resv_valid_d = resv_clr ? 1'b0 : (resv_set ? 1'b1 : resv_valid_q);
   end

   // State / control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         op_q         <= OP_LR;
         addr_q       <= '0;
         wdata_q      <= '0;
         result_q     <= '0;
         misal_q      <= 1'b0;
         resv_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         result_q     <= result_d;
         misal_q      <= misal_d;
         resv_valid_q <= resv_valid_d;
      end
   end

   // Operand registers
   always_ff @(posedge clk) begin
      rs2_q       <= rs2_d;
      f5_q        <= f5_d;
      resv_addr_q <= resv_addr_d;
   end

   // Gating with rst keeps a reset mid-access from completing a write that cycle.
   assign mem_req    = !rst && (state_q == S_RD || state_q == S_WR);
   assign mem_we     = !rst && (state_q == S_WR);
   assign mem_addr   = {addr_q, 2'b00};
   assign mem_wdata  = wdata_q;
   assign busy       = !rst && ((state_q == S_IDLE && start) || state_q == S_RD || state_q == S_WR);
   assign done       = !rst && (state_q == S_DONE);
   assign result     = result_q;
   assign misaligned = !rst && misal_q;
   assign resv_valid = resv_valid_q;

endmodule
